// File: rtl/bin_to_dec_seq_pkg.sv
// rtl/bin_to_dec_seq_pkg.sv - shared BCD constants, FSM encoding and power-of-ten helper
package bin_to_dec_seq_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // 64 bits so that 10^10 is representable for the widest digit count.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_dec_seq_add3.sv
// rtl/bin_to_dec_seq_add3.sv - conditional add-3 cell for one BCD digit
module bcd_add3
  import bin_to_dec_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= ADD3_THRESH) adjusted = digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_dec_seq.sv
// rtl/bin_to_dec_seq.sv - sequential double-dabble binary to BCD converter
module bin_to_dec_seq
  import bin_to_dec_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [BIN_W-1:0]            BIN_IN,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic [DIGIT_W*DIGITS-1:0]   BCD_OUT,
  output logic [DIGITS-1:0]           LZ_MASK,
  output logic                        OVF,
  output logic                        DONE,
  output logic                        BUSY
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam logic [BCD_W-1:0] SAT = {DIGITS{4'h9}};

  state_t state, state_nxt;
  logic accept, last_step;

  logic [BIN_W-1:0]       bin_q, bin_nxt;
  logic [BCD_W-1:0]       scratch, adj, scratch_nxt;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf_pend;
  logic [DIGITS-1:0]      lz_nxt;
  logic                   all_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit   (scratch[g*DIGIT_W +: DIGIT_W]),
      .adjusted(adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted     = {adj, bin_q} << 1;
  assign scratch_nxt = shifted[BCD_W+BIN_W-1:BIN_W];
  assign bin_nxt     = shifted[BIN_W-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    BUSY      = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          accept    = 1'b1;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        BUSY = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last_step = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz_nxt   = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero  = all_zero & (scratch_nxt[k*DIGIT_W +: DIGIT_W] == '0);
      lz_nxt[k] = all_zero;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bin_q    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      BCD_OUT  <= '0;
      LZ_MASK  <= '0;
      OVF      <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= last_step;
      if (accept) begin
        bin_q    <= BIN_IN;
        scratch  <= '0;
        cnt      <= CNT_W'(BIN_W);
        ovf_pend <= (64'(BIN_IN) >= LIMIT);
      end else if (state == ST_CONV) begin
        bin_q   <= bin_nxt;
        scratch <= scratch_nxt;
        cnt     <= cnt - CNT_W'(1);
      end
      // Results are published from the final shift so they appear with DONE.
      if (last_step) begin
        BCD_OUT <= ovf_pend ? SAT : scratch_nxt;
        LZ_MASK <= ovf_pend ? '0 : lz_nxt;
        OVF     <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_dec_seq.sv
// tb/tb_bin_to_dec_seq.sv - scoreboard bench for bin_to_dec_seq at default and 8-bit/3-digit sizes
module tb_bin_to_dec_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst, in_valid, in_ready, ovf, done, busy;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  logic [3:0]  lz_mask;

  logic        rst8, valid8, ready8, ovf8, done8, busy8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;
  logic [2:0]  lz8;

  bin_to_dec_seq dut (
    .CLK(clk), .RESET(rst), .BIN_IN(bin_in), .IN_VALID(in_valid), .IN_READY(in_ready),
    .BCD_OUT(bcd_out), .LZ_MASK(lz_mask), .OVF(ovf), .DONE(done), .BUSY(busy)
  );

  bin_to_dec_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .CLK(clk), .RESET(rst8), .BIN_IN(bin8), .IN_VALID(valid8), .IN_READY(ready8),
    .BCD_OUT(bcd8), .LZ_MASK(lz8), .OVF(ovf8), .DONE(done8), .BUSY(busy8)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  lz;
    logic        ovf;
    longint      t;
  } exp_t;

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  lz;
    logic        ovf;
    longint      t;
  } exp8_t;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [3:0]  lz;
    logic        ovf;
  } vec_t;

  exp_t  sb[$];
  exp8_t sb8[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [39:0] ref_bcd(input longint unsigned v, input int nd);
    logic [39:0] r;
    longint unsigned lim, x;
    r = '0;
    lim = 1;
    x = v;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < nd; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic [9:0] ref_lz(input longint unsigned v, input int nd);
    logic [9:0] m;
    longint unsigned lim, p;
    m = '0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v < lim) begin
      p = 1;
      for (int k = 1; k < nd; k++) begin
        p = p * 10;
        if (v < p) m[k] = 1'b1;
      end
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd_out", 64'(bcd_out), 64'(e.bcd));
        chk("lz_mask", 64'(lz_mask), 64'(e.lz));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("latency", 64'(($time - e.t - 5) / 10), 64'd14);
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected actual=1 required=0");
      end else begin
        exp8_t e;
        e = sb8.pop_front();
        chk("bcd8", 64'(bcd8), 64'(e.bcd));
        chk("lz8", 64'(lz8), 64'(e.lz));
        chk("ovf8", 64'(ovf8), 64'(e.ovf));
        chk("latency8", 64'(($time - e.t - 5) / 10), 64'd8);
      end
    end
  end

  task automatic send(input logic [13:0] v, input logic [15:0] eb, input logic [3:0] el, input logic eo);
    exp_t e;
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    bin_in = v;
    in_valid = 1'b1;
    @(posedge clk);
    e.bcd = eb;
    e.lz = el;
    e.ovf = eo;
    e.t = $time;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    bin_in = 14'($urandom);
  endtask

  task automatic send8(input int v);
    exp8_t e;
    logic [39:0] rb;
    logic [9:0] rl;
    int g;
    g = 0;
    @(negedge clk);
    while (!ready8 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("send8_ready", 64'(ready8), 64'd1);
    bin8 = 8'(v);
    valid8 = 1'b1;
    @(posedge clk);
    rb = ref_bcd(longint'(v), 3);
    rl = ref_lz(longint'(v), 3);
    e.bcd = rb[11:0];
    e.lz = rl[2:0];
    e.ovf = 1'b0;
    e.t = $time;
    sb8.push_back(e);
    @(negedge clk);
    valid8 = 1'b0;
    bin8 = 8'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || sb8.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 64'(sb.size() + sb8.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    longint t1, t2;
    int nb, nd;

    vecs[0] = '{14'd9999,  16'h9999, 4'b0000, 1'b0};
    vecs[1] = '{14'd16383, 16'h9999, 4'b0000, 1'b1};
    vecs[2] = '{14'd42,    16'h0042, 4'b1100, 1'b0};
    vecs[3] = '{14'd0,     16'h0000, 4'b1110, 1'b0};
    vecs[4] = '{14'd10000, 16'h9999, 4'b0000, 1'b1};
    vecs[5] = '{14'd1,     16'h0001, 4'b1110, 1'b0};
    vecs[6] = '{14'd10,    16'h0010, 4'b1100, 1'b0};
    vecs[7] = '{14'd100,   16'h0100, 4'b1000, 1'b0};
    vecs[8] = '{14'd1000,  16'h1000, 4'b0000, 1'b0};
    vecs[9] = '{14'd5678,  16'h5678, 4'b0000, 1'b0};

    rst = 1'b1; rst8 = 1'b1;
    in_valid = 1'b0; valid8 = 1'b0;
    bin_in = '0; bin8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_lz", 64'(lz_mask), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst8_ready", 64'(ready8), 64'd1);
    rst = 1'b0; rst8 = 1'b0;

    for (int i = 0; i < 10; i++) send(vecs[i].bin, vecs[i].bcd, vecs[i].lz, vecs[i].ovf);
    drain();

    // Back-to-back with IN_VALID held; values shown while busy must be ignored.
    @(negedge clk);
    bin_in = 14'd1000;
    in_valid = 1'b1;
    @(posedge clk);
    t1 = $time;
    sb.push_back('{16'h1000, 4'b0000, 1'b0, t1});
    nb = 0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (in_ready) break;
      nb++;
      bin_in = 14'(7000 + g);
    end
    chk("b2b_busy_cycles", 64'(nb), 64'd14);
    chk("b2b_done_with_ready", 64'(done), 64'd1);
    bin_in = 14'd999;
    @(posedge clk);
    t2 = $time;
    sb.push_back('{16'h0999, 4'b1000, 1'b0, t2});
    chk("b2b_accept_gap", 64'((t2 - t1) / 10), 64'd15);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Abort a conversion five cycles in.
    @(negedge clk);
    bin_in = 14'd3000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_busy_before", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bcd", 64'(bcd_out), 64'd0);
    chk("abort_lz", 64'(lz_mask), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    send(14'd1234, 16'h1234, 4'b0000, 1'b0);
    drain();

    // Reset wins over a simultaneous valid input.
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    bin_in = 14'd55;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("prio_busy", 64'(busy), 64'd0);
    chk("prio_ready", 64'(in_ready), 64'd1);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("prio_no_done", 64'(nd), 64'd0);

    for (int v = 0; v < 256; v++) send8(v);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
